// File: rtl/mac_feeder_pkg.sv
// Shared MAC datapath constants and the feeder read-FSM encoding.
// Also used by the MAC itself and the result collector.
package mac_feeder_pkg;

  localparam int MAC_DATA_W     = 4;
  localparam int MAC_FRAME_LEN  = 8;
  localparam int MAC_PAD_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/mac_feeder_bank.sv
// One ping-pong frame bank: DEPTH x WIDTH register file with a single write port
// and an asynchronous read mux.
module mac_feeder_bank #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mac_feeder.sv
// Buffers (IN, W) operand pairs into ping-pong frame banks and replays each full frame
// to the MAC, followed by zero pad pairs, with a frame_start strobe on the first pair.
//
//   state  | meaning
//   IDLE   | no full bank to replay, outputs zero
//   STREAM | replaying bank[rd_bank][rd_idx] to the MAC
//   PAD    | emitting zero pairs to close the MAC window
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int DATA_W     = MAC_DATA_W,
  parameter int FRAME_LEN  = MAC_FRAME_LEN,
  parameter int PAD_CYCLES = MAC_PAD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_in,
  input  logic [DATA_W-1:0] s_w,
  output logic [DATA_W-1:0] mac_in,
  output logic [DATA_W-1:0] mac_w,
  output logic              frame_start,
  output logic              frame_active,
  output logic [7:0]        frames_sent
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PAD_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [PAD_W-1:0] LAST_PAD = PAD_W'((PAD_CYCLES > 0) ? PAD_CYCLES - 1 : 0);

  feeder_state_e     state_q, state_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [PAD_W-1:0]  pad_cnt_q, pad_cnt_d;
  logic [DATA_W-1:0] mac_in_q, mac_in_d;
  logic [DATA_W-1:0] mac_w_q, mac_w_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_active_q, frame_active_d;
  logic [7:0]        frames_sent_q, frames_sent_d;

  logic                wr_fire, wr_done, rd_done;
  logic [1:0]          bank_we;
  logic [2*DATA_W-1:0] wdata, rdata0, rdata1, rd_data;

  assign s_ready = !rst && !bank_full_q[wr_bank_q];
  assign wr_fire = s_valid && s_ready;
  assign wdata   = {s_in, s_w};
  assign bank_we = {wr_fire && wr_bank_q, wr_fire && !wr_bank_q};

  // Both banks read at the upcoming index so the output registers load in step with the FSM.
  mac_feeder_bank #(.DEPTH(FRAME_LEN), .WIDTH(2*DATA_W)) u_bank0 (
    .clk(clk), .we(bank_we[0]), .waddr(wr_idx_q), .wdata(wdata),
    .raddr(rd_idx_d), .rdata(rdata0)
  );

  mac_feeder_bank #(.DEPTH(FRAME_LEN), .WIDTH(2*DATA_W)) u_bank1 (
    .clk(clk), .we(bank_we[1]), .waddr(wr_idx_q), .wdata(wdata),
    .raddr(rd_idx_d), .rdata(rdata1)
  );

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    wr_done   = 1'b0;
    if (wr_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_done   = 1'b1;
        wr_bank_d = !wr_bank_q;
        wr_idx_d  = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    pad_cnt_d = pad_cnt_q;
    rd_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = ST_STREAM;
          rd_idx_d = '0;
        end
      end
      ST_STREAM: begin
        if (rd_idx_q == LAST_IDX) begin
          rd_done   = 1'b1;
          rd_bank_d = !rd_bank_q;
          rd_idx_d  = '0;
          if (PAD_CYCLES > 0) begin
            state_d   = ST_PAD;
            pad_cnt_d = '0;
          end else begin
            state_d = bank_full_q[!rd_bank_q] ? ST_STREAM : ST_IDLE;
          end
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      ST_PAD: begin
        if (pad_cnt_q == LAST_PAD) begin
          state_d  = bank_full_q[rd_bank_q] ? ST_STREAM : ST_IDLE;
          rd_idx_d = '0;
        end else begin
          pad_cnt_d = pad_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read and write sides never own the same bank, so the two flag updates cannot collide.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_done) bank_full_d[rd_bank_q] = 1'b0;
    if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
    frames_sent_d = frames_sent_q + {7'd0, rd_done};
  end

  always_comb begin
    rd_data        = rd_bank_d ? rdata1 : rdata0;
    mac_in_d       = '0;
    mac_w_d        = '0;
    frame_start_d  = 1'b0;
    frame_active_d = (state_d != ST_IDLE);
    if (state_d == ST_STREAM) begin
      mac_in_d      = rd_data[2*DATA_W-1:DATA_W];
      mac_w_d       = rd_data[DATA_W-1:0];
      frame_start_d = (rd_idx_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bank_full_q    <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      pad_cnt_q      <= '0;
      mac_in_q       <= '0;
      mac_w_q        <= '0;
      frame_start_q  <= 1'b0;
      frame_active_q <= 1'b0;
      frames_sent_q  <= '0;
    end else begin
      state_q        <= state_d;
      bank_full_q    <= bank_full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      pad_cnt_q      <= pad_cnt_d;
      mac_in_q       <= mac_in_d;
      mac_w_q        <= mac_w_d;
      frame_start_q  <= frame_start_d;
      frame_active_q <= frame_active_d;
      frames_sent_q  <= frames_sent_d;
    end
  end

  assign mac_in       = mac_in_q;
  assign mac_w        = mac_w_q;
  assign frame_start  = frame_start_q;
  assign frame_active = frame_active_q;
  assign frames_sent  = frames_sent_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: a cycle table for a single frame, plus a queue-based model that
// expects every accepted pair to reappear in order inside a frame window.
module tb_mac_feeder;

  localparam int DW = 4;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_in = '0;
  logic [DW-1:0] s_w = '0;
  logic [DW-1:0] mac_in, mac_w;
  logic          frame_start, frame_active;
  logic [7:0]    frames_sent;

  mac_feeder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_in(s_in), .s_w(s_w), .mac_in(mac_in), .mac_w(mac_w),
    .frame_start(frame_start), .frame_active(frame_active), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_cycles = 0;

  logic [2*DW-1:0] exp_q[$];
  int start_q[$];
  int win_q[$];
  int data_left = 0;
  int win_sum = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: accepted pairs queue up in order and must come back out, unmodified,
  // as the FL pairs that start at each frame_start.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      start_q.delete();
      win_q.delete();
      data_left = 0;
    end else begin
      if (s_valid && s_ready) exp_q.push_back({s_in, s_w});
      if (frame_start) begin
        check("start_inside_frame", data_left, 0);
        data_left = FL;
        win_sum = 0;
        start_q.push_back(cyc);
      end
      if (data_left > 0) begin
        check("active_in_frame", int'(frame_active), 1);
        check("pair_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("stream_pair", int'({mac_in, mac_w}), int'(exp_q.pop_front()));
        win_sum += int'($signed(mac_in)) * int'($signed(mac_w));
        data_left--;
        if (data_left == 0) win_q.push_back(win_sum);
      end
    end
  end

  // Producer: offers pairs with the given probability and holds each one until accepted.
  task automatic send(input int n, input int vld_pct, input bit fixed,
                      input logic [DW-1:0] fin, input logic [DW-1:0] fw);
    int sent = 0;
    int budget = 40 * n + 100;
    bit pending = 0;
    bit acc;
    while (sent < n && budget > 0) begin
      if (!pending && $urandom_range(0, 99) < vld_pct) begin
        s_in = fixed ? fin : DW'($urandom);
        s_w  = fixed ? fw  : DW'($urandom);
        pending = 1;
      end
      s_valid = pending;
      #0;
      if (pending && !s_ready) stall_cycles++;
      acc = pending && s_ready;
      tick();
      budget--;
      if (acc) begin
        sent++;
        pending = 0;
      end
    end
    s_valid = 1'b0;
    check("send_count", sent, n);
  endtask

  task automatic drain();
    int budget = 200;
    while ((frame_active || exp_q.size() > 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", int'(frame_active), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic          vld;
    logic [DW-1:0] in_v;
    logic [DW-1:0] w_v;
    logic          exp_rdy;
    logic [DW-1:0] exp_in;
    logic [DW-1:0] exp_w;
    logic          exp_fs;
    logic          exp_fa;
    logic [7:0]    exp_fsent;
  } vec_t;

  vec_t tbl[19];

  initial begin
    for (int i = 0; i < 19; i++) begin
      tbl[i] = '{vld: 1'b0, in_v: '0, w_v: '0, exp_rdy: 1'b1, exp_in: '0, exp_w: '0,
                 exp_fs: 1'b0, exp_fa: 1'b0, exp_fsent: 8'd0};
      if (i < 8) begin
        tbl[i].vld  = 1'b1;
        tbl[i].in_v = DW'(i);
        tbl[i].w_v  = DW'(-i);
      end
      if (i >= 9 && i <= 16) begin
        tbl[i].exp_in = DW'(i - 9);
        tbl[i].exp_w  = DW'(-(i - 9));
        tbl[i].exp_fs = (i == 9);
        tbl[i].exp_fa = 1'b1;
      end
      if (i == 17) tbl[i].exp_fa = 1'b1;
      if (i >= 17) tbl[i].exp_fsent = 8'd1;
    end

    // Reset held for three cycles with a producer already offering data.
    rst = 1'b1;
    s_valid = 1'b1;
    s_in = 4'd5;
    s_w = 4'd3;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", int'(s_ready), 0);
      check("rst_mac_in", int'(mac_in), 0);
      check("rst_mac_w", int'(mac_w), 0);
      check("rst_fs_fa", int'({frame_start, frame_active}), 0);
      check("rst_frames_sent", int'(frames_sent), 0);
      if (i < 2) tick();
    end
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    check("post_rst_ready", int'(s_ready), 1);
    check("post_rst_mac_in", int'(mac_in), 0);

    // Single frame (k, -k), cycle by cycle.
    for (int i = 0; i < 19; i++) begin
      s_valid = tbl[i].vld;
      s_in = tbl[i].in_v;
      s_w = tbl[i].w_v;
      #1;
      check("t2_ready", int'(s_ready), int'(tbl[i].exp_rdy));
      check("t2_mac_in", int'(mac_in), int'(tbl[i].exp_in));
      check("t2_mac_w", int'(mac_w), int'(tbl[i].exp_w));
      check("t2_frame_start", int'(frame_start), int'(tbl[i].exp_fs));
      check("t2_frame_active", int'(frame_active), int'(tbl[i].exp_fa));
      check("t2_frames_sent", int'(frames_sent), int'(tbl[i].exp_fsent));
      tick();
    end
    s_valid = 1'b0;

    // Back-to-back: 24 pairs, three frames on a 9-cycle period, one stall while both banks are full.
    do_reset(2);
    stall_cycles = 0;
    send(24, 100, 1'b0, '0, '0);
    drain();
    check("t3_frames_sent", int'(frames_sent), 3);
    check("t3_stall_cycles", stall_cycles, 1);
    check("t3_start_count", start_q.size(), 3);
    if (start_q.size() >= 3) begin
      check("t3_period_a", start_q[1] - start_q[0], 9);
      check("t3_period_b", start_q[2] - start_q[1], 9);
    end

    // Random bubbles, a long producer stall, then a dense burst.
    do_reset(2);
    send(56, 60, 1'b0, '0, '0);
    repeat (20) tick();
    send(40, 90, 1'b0, '0, '0);
    drain();
    check("t4_frames_sent", int'(frames_sent), 12);

    // Reset while streaming rd_idx=4, with the other bank partially written.
    do_reset(2);
    send(8, 100, 1'b0, '0, '0);
    drain();
    check("t5_pre_frames_sent", int'(frames_sent), 1);
    send(12, 100, 1'b0, '0, '0);
    tick();
    check("t5_mid_stream", int'(frame_active), 1);
    rst = 1'b1;
    tick();
    check("t5_rst_mac_in", int'(mac_in), 0);
    check("t5_rst_mac_w", int'(mac_w), 0);
    check("t5_rst_active", int'(frame_active), 0);
    check("t5_rst_frames_sent", int'(frames_sent), 0);
    rst = 1'b0;
    #1;
    check("t5_ready_after", int'(s_ready), 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t5_no_stale_frame", int'(frame_active), 0);
    end
    send(8, 100, 1'b0, '0, '0);
    drain();
    check("t5_frames_sent", int'(frames_sent), 1);

    // Window sums as the MAC would accumulate them.
    do_reset(2);
    send(8, 100, 1'b1, 4'd7, 4'h8);
    send(8, 100, 1'b1, 4'h8, 4'h8);
    drain();
    check("t6_window_count", win_q.size(), 2);
    if (win_q.size() >= 2) begin
      check("t6_window_7x-8", win_q[0], -448);
      check("t6_window_-8x-8", win_q[1], 512);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
